// File: rtl/adc_touch_pkg.sv
// Shared FSM encoding, frame constants and command-bit lookup for the touchscreen ADC sequencer.
package adc_touch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FRAME = 2'd1,
      ST_DONE  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam logic [6:0] FRAME_LAST   = 7'd81;
   localparam logic [6:0] XCMD_START   = 7'd2;
   localparam logic [6:0] YCMD_START   = 7'd34;
   localparam logic [6:0] X_DATA_START = 7'd18;
   localparam logic [6:0] Y_DATA_START = 7'd50;
   localparam logic [6:0] CMD_SPAN     = 7'd16;

   // Each command bit occupies one count pair, so bit index falls by one every two counts.
   function automatic logic din_bit(input logic [6:0] cnt,
                                    input logic [7:0] cmd_x,
                                    input logic [7:0] cmd_y);
      logic [6:0] off;
      logic [2:0] idx;
      off     = 7'd0;
      idx     = 3'd0;
      din_bit = 1'b0;
      if (cnt >= XCMD_START && cnt < XCMD_START + CMD_SPAN) begin
         off     = cnt - XCMD_START;
         idx     = 3'd7 - off[3:1];
         din_bit = cmd_x[idx];
      end else if (cnt >= YCMD_START && cnt < YCMD_START + CMD_SPAN) begin
         off     = cnt - YCMD_START;
         idx     = 3'd7 - off[3:1];
         din_bit = cmd_y[idx];
      end
   endfunction

endpackage

// File: rtl/adc_touch_ctrl_sync2.sv
// Two-flop synchroniser with a parameterised reset value; 2 CLK latency, no backpressure.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RST_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         meta_q <= RST_VAL;
         q      <= RST_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/adc_touch_ctrl.sv
// Touchscreen ADC frame sequencer: pen-down detect, 82-count serial frame, Coord_valid pulse.
// All pin outputs registered; CS_n falls 1 CLK after Pen_down, Coord_valid 1 CLK after count 81.
module adc_touch_ctrl
   import adc_touch_pkg::*;
#(
   parameter int         DIV   = 25,
   parameter logic [7:0] CMD_X = 8'h92,
   parameter logic [7:0] CMD_Y = 8'hD2,
   parameter int         GAP   = 5000
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic       Enable,
   input  logic       ADC_PENIRQ_n,
   output logic       ADC_DCLK,
   output logic       ADC_CS_n,
   output logic       ADC_DIN,
   output logic [6:0] Cuenta,
   output logic       Enable1,
   output logic       Enable2,
   output logic       Coord_valid,
   output logic       Pen_down
);

   localparam int DW = $clog2(DIV);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t          state_q, state_nx;
   logic [DW-1:0]   div_q, div_nx;
   logic [6:0]      cuenta_q, cuenta_nx;
   logic [GW-1:0]   gap_q, gap_nx;
   logic            pen_sync;
   logic            tick;
   logic            frame_nx;
   logic            cv_nx;
   logic            dclk_q, cs_n_q, din_q, en1_q, en2_q, cv_q;

   sync2 #(.RST_VAL(1'b1)) u_pen_sync (
      .CLK   (CLK),
      .RST_n (RST_n),
      .d     (ADC_PENIRQ_n),
      .q     (pen_sync)
   );

   assign Pen_down = ~pen_sync;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         cuenta_q <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_nx;
         div_q    <= div_nx;
         cuenta_q <= cuenta_nx;
         gap_q    <= gap_nx;
      end
   end

   always_comb begin
      state_nx  = state_q;
      div_nx    = div_q;
      cuenta_nx = cuenta_q;
      gap_nx    = gap_q;
      cv_nx     = 1'b0;
      tick      = (div_q == DW'(DIV - 1));
      case (state_q)
         ST_IDLE: begin
            div_nx    = '0;
            cuenta_nx = '0;
            if (Enable && Pen_down) state_nx = ST_FRAME;
         end
         ST_FRAME: begin
            if (tick) begin
               div_nx = '0;
               if (cuenta_q == FRAME_LAST) begin
                  state_nx  = ST_DONE;
                  cuenta_nx = '0;
                  cv_nx     = Pen_down;
               end else begin
                  cuenta_nx = cuenta_q + 7'd1;
               end
            end else begin
               div_nx = div_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_nx = ST_GAP;
            gap_nx   = '0;
         end
         ST_GAP: begin
            if (gap_q == GW'(GAP - 1)) state_nx = ST_IDLE;
            else                       gap_nx   = gap_q + 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
      frame_nx = (state_nx == ST_FRAME);
   end

   // Pin values are derived from next-state counters so every pin toggles on the same edge as Cuenta.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         dclk_q <= 1'b0;
         cs_n_q <= 1'b1;
         din_q  <= 1'b0;
         en1_q  <= 1'b0;
         en2_q  <= 1'b0;
         cv_q   <= 1'b0;
      end else begin
         dclk_q <= frame_nx & cuenta_nx[0];
         cs_n_q <= ~frame_nx;
         din_q  <= frame_nx & din_bit(cuenta_nx, CMD_X, CMD_Y);
         en1_q  <= frame_nx;
         en2_q  <= frame_nx & cuenta_nx[0] & (div_nx == DW'(DIV - 1));
         cv_q   <= cv_nx;
      end
   end

   assign ADC_DCLK    = dclk_q;
   assign ADC_CS_n    = cs_n_q;
   assign ADC_DIN     = din_q;
   assign Cuenta      = cuenta_q;
   assign Enable1     = en1_q;
   assign Enable2     = en2_q;
   assign Coord_valid = cv_q;

endmodule
